sw_tile_scheduler: RTL and testbench

- Sequences one 16x16 anti-diagonal scoring tile over a full alignment of up to MAX_TA x MAX_TB tiles, visiting tiles in row-major order.
- Supplies each tile's first row, first column and diagonal corner. Stores each tile's last row and last column for its neighbours.
- Tracks the global maximum score and the tile that produced it.
- Sits between the alignment top level (config/start/done) and the single tile datapath instance.

---
 rtl/sw_pkg.sv | 18 +
 rtl/sw_tile_scheduler_if.sv | 30 +++
 rtl/sw_row_buffer.sv | 31 +++
 rtl/sw_tile_scheduler.sv | 162 ++++++++++++++++
 tb/tb_sw_tile_scheduler.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/sw_pkg.sv
// Shared types for the Smith-Waterman tile scheduler slice.
// Boundary vectors pack element k at [k*SCORE_W +: SCORE_W].
package sw_pkg;
    localparam int TILE    = 16;
    localparam int SCORE_W = 8;

    typedef logic [SCORE_W-1:0] score_t;
    typedef score_t [TILE-1:0] bnd_t;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        STORE,
        FIN
    } state_t;
endpackage

// File: rtl/sw_tile_scheduler_if.sv
// Scheduler <-> tile datapath bundle: issue side (master) and
// completion side (slave).
interface sw_tile_scheduler_if #(
    parameter int IDX_W = 3
);
    import sw_pkg::*;

    logic             tile_start;
    logic [IDX_W-1:0] tile_r;
    logic [IDX_W-1:0] tile_c;
    bnd_t             first_row;
    bnd_t             first_col;
    score_t           diag_cell;
    logic             tile_done;
    bnd_t             tile_last_row;
    bnd_t             tile_last_col;
    score_t           tile_max;

    modport master (
        output tile_start, tile_r, tile_c,
        output first_row, first_col, diag_cell,
        input  tile_done, tile_last_row, tile_last_col, tile_max
    );

    modport slave (
        input  tile_start, tile_r, tile_c,
        input  first_row, first_col, diag_cell,
        output tile_done, tile_last_row, tile_last_col, tile_max
    );
endinterface

// File: rtl/sw_row_buffer.sv
// Per-column store of the last row of the tile above; one read and
// one write per cycle, read returns pre-write data.
module sw_row_buffer
    import sw_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  bnd_t          wdata,
    input  logic [AW-1:0] raddr,
    output bnd_t          rdata
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    bnd_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (we && int'(waddr) < DEPTH) begin
            mem[waddr[IW-1:0]] <= wdata;
        end
    end

    // Plain register read: a same-cycle write lands only at the edge.
    assign rdata = (int'(raddr) < DEPTH) ? mem[raddr[IW-1:0]] : '0;
endmodule

// File: rtl/sw_tile_scheduler.sv
// Row-major tile sequencer with boundary forwarding and global max.
// Optional SCHED_WATCHDOG_EN adds a WAIT timeout and err output.
module sw_tile_scheduler
    import sw_pkg::*;
#(
    parameter int MAX_TA = 4,
    parameter int MAX_TB = 4,
    parameter int IDX_W  = 3
`ifdef SCHED_WATCHDOG_EN
    ,
    parameter int WD_LIMIT = 1023
`endif
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [IDX_W-1:0]   cfg_tiles_a,
    input  logic [IDX_W-1:0]   cfg_tiles_b,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] max_score,
    output logic [IDX_W-1:0]   max_tile_r,
    output logic [IDX_W-1:0]   max_tile_c,
`ifdef SCHED_WATCHDOG_EN
    output logic               err,
`endif
    sw_tile_scheduler_if.master tile
);
    state_t           state;
    logic [IDX_W-1:0] ta, tb, r, c;
    bnd_t             colreg, lr, lc, rb_rdata;
    score_t           corner, tmax;
    logic             last_c, last_t;
`ifdef SCHED_WATCHDOG_EN
    logic [15:0]      wd_cnt;
`endif

    assign last_c = (c == tb - 1'b1);
    assign last_t = last_c && (r == ta - 1'b1);

    sw_row_buffer #(
        .DEPTH (MAX_TB),
        .AW    (IDX_W)
    ) u_rowbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (state == STORE),
        .waddr (c),
        .wdata (lr),
        .raddr (c),
        .rdata (rb_rdata)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= IDLE;
            busy            <= 1'b0;
            done            <= 1'b0;
            max_score       <= '0;
            max_tile_r      <= '0;
            max_tile_c      <= '0;
            ta              <= '0;
            tb              <= '0;
            r               <= '0;
            c               <= '0;
            colreg          <= '0;
            corner          <= '0;
            lr              <= '0;
            lc              <= '0;
            tmax            <= '0;
            tile.tile_start <= 1'b0;
            tile.tile_r     <= '0;
            tile.tile_c     <= '0;
            tile.first_row  <= '0;
            tile.first_col  <= '0;
            tile.diag_cell  <= '0;
`ifdef SCHED_WATCHDOG_EN
            err             <= 1'b0;
            wd_cnt          <= '0;
`endif
        end else begin
            tile.tile_start <= 1'b0;
            done            <= 1'b0;
            unique case (state)
                IDLE: if (start) begin
                    ta         <= (int'(cfg_tiles_a) > MAX_TA) ? IDX_W'(MAX_TA) : cfg_tiles_a;
                    tb         <= (int'(cfg_tiles_b) > MAX_TB) ? IDX_W'(MAX_TB) : cfg_tiles_b;
                    r          <= '0;
                    c          <= '0;
                    max_score  <= '0;
                    max_tile_r <= '0;
                    max_tile_c <= '0;
                    busy       <= 1'b1;
`ifdef SCHED_WATCHDOG_EN
                    err        <= 1'b0;
`endif
                    // Empty runs also pass through LOAD so done keeps a
                    // fixed two-cycle latency from start.
                    state      <= LOAD;
                end
                LOAD: begin
                    if (ta == '0 || tb == '0) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        tile.first_row  <= (r == '0) ? '0 : rb_rdata;
                        tile.first_col  <= (c == '0) ? '0 : colreg;
                        tile.diag_cell  <= (r == '0 || c == '0) ? '0 : corner;
                        tile.tile_start <= 1'b1;
                        tile.tile_r     <= r;
                        tile.tile_c     <= c;
                        state           <= ISSUE;
                    end
                end
                ISSUE: begin
`ifdef SCHED_WATCHDOG_EN
                    wd_cnt <= '0;
`endif
                    state <= WAIT;
                end
                WAIT: begin
                    if (tile.tile_done) begin
                        lr    <= tile.tile_last_row;
                        lc    <= tile.tile_last_col;
                        tmax  <= tile.tile_max;
                        state <= STORE;
`ifdef SCHED_WATCHDOG_EN
                    end else if (wd_cnt == 16'(WD_LIMIT - 1)) begin
                        err   <= 1'b1;
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 16'd1;
`endif
                    end
                end
                STORE: begin
                    corner <= rb_rdata[TILE-1];
                    colreg <= lc;
                    if (tmax > max_score) begin
                        max_score  <= tmax;
                        max_tile_r <= r;
                        max_tile_c <= c;
                    end
                    if (last_t) begin
                        done  <= 1'b1;
                        state <= FIN;
                    end else begin
                        c     <= last_c ? '0 : c + 1'b1;
                        r     <= last_c ? r + 1'b1 : r;
                        state <= LOAD;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sw_tile_scheduler.sv
// Directed bench for sw_tile_scheduler; the bench plays the tile
// datapath and predicts boundaries, latencies and the global max.
module tb_sw_tile_scheduler;
    import sw_pkg::*;

    localparam int IDX_W = 3;
    localparam int WD    = 1023;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [IDX_W-1:0]   cfg_a = '0;
    logic [IDX_W-1:0]   cfg_b = '0;
    logic               busy, done;
    logic [SCORE_W-1:0] max_score;
    logic [IDX_W-1:0]   max_tile_r, max_tile_c;
`ifdef SCHED_WATCHDOG_EN
    logic               err;
`endif

    int     n_run  = 0;
    int     n_fail = 0;
    score_t tmtab [16];

    sw_tile_scheduler_if #(.IDX_W(IDX_W)) tif ();

    sw_tile_scheduler #(
        .MAX_TA (4),
        .MAX_TB (4),
        .IDX_W  (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_tiles_a (cfg_a),
        .cfg_tiles_b (cfg_b),
        .busy        (busy),
        .done        (done),
        .max_score   (max_score),
        .max_tile_r  (max_tile_r),
        .max_tile_c  (max_tile_c),
`ifdef SCHED_WATCHDOG_EN
        .err         (err),
`endif
        .tile        (tif.master)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bnd_t blk(input int r, input int c, input int nb);
        bnd_t v;
        for (int k = 0; k < TILE; k++) v[k] = 8'(16 * (r * nb + c + 1) + k);
        return v;
    endfunction

    task automatic run(input int a, input int b, input int abort_at);
        int     n, idx;
        int     er, ec;
        score_t emax;
        bnd_t   ex, pr;
        bit     seen;
        emax  = '0;
        er    = 0;
        ec    = 0;
        cfg_a = IDX_W'(a);
        cfg_b = IDX_W'(b);
        start = 1'b1;
        tick();
        start = 1'b0;
        n     = 1;
        idx   = 0;
        for (int r = 0; r < a; r++) begin
            for (int c = 0; c < b; c++) begin
                while (!tif.tile_start && n < 20) begin
                    tick();
                    n++;
                end
                chk("start_lat", n, (idx == 0) ? 2 : 3);
                chk("tile_r", tif.tile_r, r);
                chk("tile_c", tif.tile_c, c);
                ex = (r == 0) ? '0 : blk(r - 1, c, b);
                chk("first_row", tif.first_row, ex);
                ex = (c == 0) ? '0 : blk(r, c - 1, b);
                chk("first_col", tif.first_col, ex);
                pr = blk(r - 1, c - 1, b);
                chk("diag", tif.diag_cell,
                    (r == 0 || c == 0) ? 8'h00 : pr[TILE-1]);
                chk("busy", busy, 1);
                if (idx == abort_at) begin
                    tick();
                    rst = 1'b1;
                    tick();
                    chk("rst_busy", busy, 0);
                    chk("rst_done", done, 0);
                    chk("rst_start", tif.tile_start, 0);
                    chk("rst_max", max_score, 0);
                    chk("rst_fcol", tif.first_col, 0);
                    chk("rst_tile_c", tif.tile_c, 0);
                    rst  = 1'b0;
                    seen = 1'b0;
                    for (int i = 0; i < 6; i++) begin
                        tick();
                        if (done) seen = 1'b1;
                    end
                    chk("rst_no_done", seen, 0);
                    return;
                end
                tick();
                tick();
                tile_done_drive(blk(r, c, b), tmtab[idx]);
                if (tmtab[idx] > emax) begin
                    emax = tmtab[idx];
                    er   = r;
                    ec   = c;
                end
                n = 1;
                idx++;
            end
        end
        seen = 1'b0;
        while (!done && n < 20) begin
            tick();
            n++;
            if (tif.tile_start) seen = 1'b1;
        end
        chk("done_lat", n, 2);
        chk("no_extra_tile", seen, 0);
        chk("max_score", max_score, emax);
        chk("max_r", max_tile_r, er);
        chk("max_c", max_tile_c, ec);
        tick();
        chk("idle", busy, 0);
    endtask

    task automatic tile_done_drive(input bnd_t v, input score_t m);
        tif.tile_done     = 1'b1;
        tif.tile_last_row = v;
        tif.tile_last_col = v;
        tif.tile_max      = m;
        tick();
        tif.tile_done     = 1'b0;
    endtask

    initial begin
        tif.tile_done     = 1'b0;
        tif.tile_last_row = '0;
        tif.tile_last_col = '0;
        tif.tile_max      = '0;
        tick();
        tick();
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_max", max_score, 0);
        chk("reset_tstart", tif.tile_start, 0);
        chk("reset_frow", tif.first_row, 0);
        rst = 1'b0;
        tick();

        tmtab[0] = 8'h2A;
        run(1, 1, -1);

        tmtab[0] = 8'h11;
        tmtab[1] = 8'h40;
        tmtab[2] = 8'h33;
        tmtab[3] = 8'h40;
        run(2, 2, -1);

        run(0, 3, -1);

        tmtab[0] = 8'h30;
        tmtab[1] = 8'h30;
        tmtab[2] = 8'h20;
        run(1, 3, -1);

        tmtab[0] = 8'h55;
        tmtab[1] = 8'h66;
        run(1, 2, 1);

        tmtab[0] = 8'h07;
        run(1, 1, -1);

`ifdef SCHED_WATCHDOG_EN
        begin
            int n;
            cfg_a = 3'd1;
            cfg_b = 3'd1;
            start = 1'b1;
            tick();
            start = 1'b0;
            n = 0;
            while (!tif.tile_start && n < 20) begin
                tick();
                n++;
            end
            n = 0;
            while (!done && n < WD + 20) begin
                tick();
                n++;
            end
            chk("wd_lat", n, WD + 1);
            chk("wd_err", err, 1);
            chk("wd_max", max_score, 0);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
